recipe_checker: RTL and testbench
=================================

# recipe_checker

Consumer of the 18-bit recipe word produced by the recipe generator. Latches a recipe on `start`, then compares each caught cake layer, one per `layer_valid` strobe, against the expected layer in stacking order: layer1 through layer5, then the cherry. It reports per-layer match/miss pulses, the next expected colour for the display, a running score, and a final pass/fail verdict. It sits between the catch/collision logic and the game-state controller.

## Interface
- `TIMEOUT`, default 28'd250_000_000: cycles allowed per layer before the round fails (5 s at 50 MHz).
- `MAX_MISSES`, default 3: misses tolerated when retry is compiled in.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: pulse; latch `recipe` and begin a round.
- `recipe` in 18: {cherry[17:15], layer1[14:12], layer2[11:9], layer3[8:6], layer4[5:3], layer5[2:0]}.
- `layer_valid` in 1: one-cycle strobe; a caught layer is presented.
- `layer_clr` in 3: colour of the caught layer.
- `ready` out 1: block is in CHECK and accepting layers.
- `expected_clr` out 3: colour of the next layer required.
- `layer_ok` out 1: one-cycle pulse; the last accepted layer matched.
- `layer_bad` out 1: one-cycle pulse; the last accepted layer mismatched.
- `score` out 3: matched layers so far, 0..6.
- `misses` out 3: mismatches so far, saturating at 7.
- `done` out 1: round finished; held until the next `start` or `reset`.
- `pass` out 1: valid when `done`; 1 means all 6 layers matched.

## Operation
- States: IDLE, LOAD, CHECK, DONE.
- IDLE → LOAD on `start`.
  - LOAD registers `recipe`, sets idx=0, clears `score`, `misses`, `done`, `pass` and the timer.
  - LOAD → CHECK unconditionally.
- CHECK: `expected_clr` = recipe slice for idx (0 → layer1 … 4 → layer5, 5 → cherry).
  - On `layer_valid` with `layer_clr` ≠ 3'b000, the layer is accepted and compared.
  - `layer_clr` = 3'b000 (no layer) is ignored: no pulse, no timer restart.
  - Match: `layer_ok` pulses, `score`+1, idx+1, timer restarts. A match at idx=5 → DONE with `pass`=1.
  - Mismatch without retry: `layer_bad` pulses, `misses`+1, → DONE with `pass`=0.
- Timer counts every cycle in CHECK. Reaching `TIMEOUT`-1 → DONE with `pass`=0 and no pulse.
- `start` in CHECK or DONE aborts the round and re-enters LOAD. On a simultaneous `start` and `layer_valid`, `start` wins and the layer is dropped.
- Any state with `reset` → IDLE. `reset` dominates `start`.
- Reset values: `ready`, `layer_ok`, `layer_bad`, `done`, `pass` = 0; `score`, `misses`, `expected_clr` = 0.
- In IDLE, `expected_clr` = 0.

## Timing
- `start` at cycle N: LOAD at N+1, `ready`=1 and `expected_clr` valid from N+2.
- Layer accepted at cycle M:
  - `layer_ok`/`layer_bad` at M+1.
  - `score` and `expected_clr` updated at M+1.
  - `done` at M+1 when terminal.
- A new layer may be accepted every cycle while `ready`=1.
- `ready` drops in the same cycle `done` rises.
- A timeout in cycle T gives `done` at T+1.
- All outputs are registered.

## Configuration
- `RECIPE_CHECK_RETRY_EN` defined: a mismatch pulses `layer_bad`, increments `misses`, holds idx and restarts the timer. The round fails (→ DONE, `pass`=0) only when `misses` reaches `MAX_MISSES`.
- Undefined: the first mismatch ends the round. `MAX_MISSES` is unused.

## Structure
- Shared package `recipe_pkg` holds:
  - `RECIPE_W`=18 and `CLR_W`=3.
  - `CLR_NONE`=3'b000 and `CLR_CHERRY`=3'b111.
  - `NUM_LAYERS`=6.
  - Slice offset constants.
  - The state enum.
- One sub-module, `recipe_layer_sel`: combinational 3-bit slice mux of the latched recipe by idx. idx > 5 returns `CLR_NONE`.

## Test plan
- Recipe 18'o712345, feed 1,2,3,4,5,7 back-to-back → six `layer_ok` pulses, `score`=6, `done`=1, `pass`=1 one cycle after the cherry.
- Same recipe, feed 1,2,6 with retry off → `layer_bad` at the third layer, `score`=2, `misses`=1, `done`=1, `pass`=0.
- Retry on, `MAX_MISSES`=3, feed 1,6,6,2… → `expected_clr` stays 2 after each miss; the third miss gives `done` with `pass`=0 and `misses`=3.
- `TIMEOUT`=16, accept layer1, then idle 16 cycles → `done`=1, `pass`=0, `score`=1, no `layer_bad`.
- `layer_valid` with `layer_clr`=0 mid-round → no pulse, idx unchanged. `start` together with `layer_valid` → round restarts, `score`=0, layer dropped.
- Assert `reset` mid-round at idx=3 → next cycle all outputs 0, state IDLE, `ready`=0.

Source files
------------

// File: rtl/recipe_pkg.sv
// Shared types and constants for the recipe checker: word layout, colour codes, FSM states.
package recipe_pkg;

    localparam int RECIPE_W   = 18;
    localparam int CLR_W      = 3;
    localparam int NUM_LAYERS = 6;
    localparam int IDX_W      = 3;

    localparam logic [CLR_W-1:0] CLR_NONE   = 3'b000;
    localparam logic [CLR_W-1:0] CLR_CHERRY = 3'b111;

    // Bit offsets of each 3-bit slice inside the 18-bit recipe word
    localparam int CHERRY_LSB = 15;
    localparam int LAYER1_LSB = 12;
    localparam int LAYER2_LSB = 9;
    localparam int LAYER3_LSB = 6;
    localparam int LAYER4_LSB = 3;
    localparam int LAYER5_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/recipe_layer_sel.sv
// Picks the colour slice of the latched recipe for a stacking index
// (0..4 = layer1..layer5, 5 = cherry, anything else = no layer).
module recipe_layer_sel
    import recipe_pkg::*;
(
    input  logic [RECIPE_W-1:0] recipe_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [CLR_W-1:0]    clr_o
);

    always_comb begin
        clr_o = CLR_NONE;
        case (idx_i)
            3'd0:    clr_o = recipe_i[LAYER1_LSB +: CLR_W];
            3'd1:    clr_o = recipe_i[LAYER2_LSB +: CLR_W];
            3'd2:    clr_o = recipe_i[LAYER3_LSB +: CLR_W];
            3'd3:    clr_o = recipe_i[LAYER4_LSB +: CLR_W];
            3'd4:    clr_o = recipe_i[LAYER5_LSB +: CLR_W];
            3'd5:    clr_o = recipe_i[CHERRY_LSB +: CLR_W];
            default: clr_o = CLR_NONE;
        endcase
    end

endmodule

// File: rtl/recipe_checker.sv
// Checks caught cake layers against a latched recipe and scores the round.
// Define RECIPE_CHECK_RETRY_EN to let a round survive up to MAX_MISSES-1 mismatches.
module recipe_checker
    import recipe_pkg::*;
#(
    parameter logic [27:0] TIMEOUT    = 28'd250_000_000,
    parameter int          MAX_MISSES = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [RECIPE_W-1:0] recipe_i,
    input  logic                layer_valid_i,
    input  logic [CLR_W-1:0]    layer_clr_i,
    output logic                ready_o,
    output logic [CLR_W-1:0]    expected_clr_o,
    output logic                layer_ok_o,
    output logic                layer_bad_o,
    output logic [2:0]          score_o,
    output logic [2:0]          misses_o,
    output logic                done_o,
    output logic                pass_o
);

`ifdef RECIPE_CHECK_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    // Without retry the very first miss is fatal, i.e. a limit of one
    localparam int          MISS_LIMIT_I = RETRY_EN ? ((MAX_MISSES > 7) ? 7 : MAX_MISSES) : 1;
    localparam logic [2:0]  MISS_LIMIT   = MISS_LIMIT_I[2:0];
    localparam logic [27:0] TMR_RELOAD   = TIMEOUT - 28'd1;

    state_e                state_q, state_d;
    logic [RECIPE_W-1:0]   recipe_q, recipe_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [27:0]           timer_q, timer_d;
    logic [2:0]            score_q, score_d;
    logic [2:0]            misses_q, misses_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  ok_q, ok_d;
    logic                  bad_q, bad_d;
    logic                  ready_q, ready_d;
    logic [CLR_W-1:0]      exp_q, exp_d;
    logic [CLR_W-1:0]      sel_clr;
    logic                  accept;
    logic [2:0]            misses_inc;

    recipe_layer_sel u_sel (
        .recipe_i (recipe_q),
        .idx_i    (idx_d),
        .clr_o    (sel_clr)
    );

    assign accept     = layer_valid_i && (layer_clr_i != CLR_NONE);
    assign misses_inc = (misses_q == 3'd7) ? 3'd7 : misses_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        recipe_d = recipe_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        score_d  = score_q;
        misses_d = misses_q;
        done_d   = done_q;
        pass_d   = pass_q;
        ok_d     = 1'b0;
        bad_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    recipe_d = recipe_i;
                    idx_d    = '0;
                    score_d  = '0;
                    misses_d = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    timer_d  = TMR_RELOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_CHECK;
                idx_d   = '0;
                timer_d = TMR_RELOAD;
            end
            ST_CHECK: begin
                // exp_q already holds the colour for idx_q while in CHECK
                if (start_i) begin
                    state_d  = ST_LOAD;
                    recipe_d = recipe_i;
                    idx_d    = '0;
                    score_d  = '0;
                    misses_d = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    timer_d  = TMR_RELOAD;
                end else if (accept) begin
                    timer_d = TMR_RELOAD;
                    if (layer_clr_i == exp_q) begin
                        ok_d    = 1'b1;
                        score_d = score_q + 3'd1;
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == IDX_W'(NUM_LAYERS - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end
                    end else begin
                        bad_d    = 1'b1;
                        misses_d = misses_inc;
                        if (misses_inc >= MISS_LIMIT) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b0;
                        end
                    end
                end else if (timer_q == 28'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    recipe_d = recipe_i;
                    idx_d    = '0;
                    score_d  = '0;
                    misses_d = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    timer_d  = TMR_RELOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_CHECK);
        exp_d   = (state_d == ST_CHECK) ? sel_clr : CLR_NONE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            recipe_q <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            score_q  <= '0;
            misses_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
            ready_q  <= 1'b0;
            exp_q    <= CLR_NONE;
        end else begin
            state_q  <= state_d;
            recipe_q <= recipe_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
            ready_q  <= ready_d;
            exp_q    <= exp_d;
        end
    end

    assign ready_o        = ready_q;
    assign expected_clr_o = exp_q;
    assign layer_ok_o     = ok_q;
    assign layer_bad_o    = bad_q;
    assign score_o        = score_q;
    assign misses_o       = misses_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;

endmodule

// File: tb/tb_recipe_checker.sv
// Directed bench for recipe_checker: a vector table for the main rounds plus
// hand-written sequences for timeout, start/layer collision and mid-round reset.
module tb_recipe_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [17:0] recipe;
    logic        layer_valid;
    logic [2:0]  layer_clr;
    logic        ready;
    logic [2:0]  expected_clr;
    logic        layer_ok;
    logic        layer_bad;
    logic [2:0]  score;
    logic [2:0]  misses;
    logic        done;
    logic        pass;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    recipe_checker #(
        .TIMEOUT    (28'd16),
        .MAX_MISSES (3)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .recipe_i       (recipe),
        .layer_valid_i  (layer_valid),
        .layer_clr_i    (layer_clr),
        .ready_o        (ready),
        .expected_clr_o (expected_clr),
        .layer_ok_o     (layer_ok),
        .layer_bad_o    (layer_bad),
        .score_o        (score),
        .misses_o       (misses),
        .done_o         (done),
        .pass_o         (pass)
    );

    typedef struct {
        logic       st;
        logic       vld;
        logic [2:0] clr;
        logic       ok;
        logic       bd;
        logic [2:0] sc;
        logic [2:0] ms;
        logic [2:0] ecl;
        logic       rdy;
        logic       dn;
        logic       ps;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic vld, input logic [2:0] clr,
                                input logic ok, input logic bd, input logic [2:0] sc,
                                input logic [2:0] ms, input logic [2:0] ecl,
                                input logic rdy, input logic dn, input logic ps);
        vec_t v;
        v.st = st;  v.vld = vld; v.clr = clr;
        v.ok = ok;  v.bd = bd;   v.sc = sc;  v.ms = ms;
        v.ecl = ecl; v.rdy = rdy; v.dn = dn; v.ps = ps;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".ok"},     32'(layer_ok),     32'(v.ok));
        chk({tag, ".bad"},    32'(layer_bad),    32'(v.bd));
        chk({tag, ".score"},  32'(score),        32'(v.sc));
        chk({tag, ".misses"}, 32'(misses),       32'(v.ms));
        chk({tag, ".exp"},    32'(expected_clr), 32'(v.ecl));
        chk({tag, ".ready"},  32'(ready),        32'(v.rdy));
        chk({tag, ".done"},   32'(done),         32'(v.dn));
        chk({tag, ".pass"},   32'(pass),         32'(v.ps));
    endtask

    task automatic start_round;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start.ready", 32'(ready), 32'd1);
        chk("start.exp",   32'(expected_clr), 32'd1);
    endtask

    task automatic feed(input logic [2:0] c);
        layer_valid = 1'b1;
        layer_clr   = c;
        tick();
        layer_valid = 1'b0;
        layer_clr   = 3'd0;
    endtask

    initial begin
        logic bad_seen;

        reset       = 1'b1;
        start       = 1'b0;
        layer_valid = 1'b0;
        layer_clr   = 3'd0;
        recipe      = 18'o712345;
        tick();
        tick();
        check_all("rst", mk(0,0,0, 0,0,0,0,0,0,0,0));
        reset = 1'b0;
        tick();
        chk("idle.ready", 32'(ready), 32'd0);

        //            st vld clr  ok bd sc ms ecl rdy dn ps
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,1,1,0,0));
        vecs.push_back(mk(0,1,1, 1,0,1,0,2,1,0,0));
        vecs.push_back(mk(0,1,2, 1,0,2,0,3,1,0,0));
        vecs.push_back(mk(0,1,3, 1,0,3,0,4,1,0,0));
        vecs.push_back(mk(0,1,4, 1,0,4,0,5,1,0,0));
        vecs.push_back(mk(0,1,5, 1,0,5,0,7,1,0,0));
        vecs.push_back(mk(0,1,7, 1,0,6,0,0,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0,6,0,0,0,1,1));
        vecs.push_back(mk(0,1,3, 0,0,6,0,0,0,1,1));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,1,1,0,0));
        vecs.push_back(mk(0,1,0, 0,0,0,0,1,1,0,0));
        vecs.push_back(mk(0,1,1, 1,0,1,0,2,1,0,0));
        vecs.push_back(mk(0,1,2, 1,0,2,0,3,1,0,0));
`ifdef RECIPE_CHECK_RETRY_EN
        vecs.push_back(mk(0,1,6, 0,1,2,1,3,1,0,0));
        vecs.push_back(mk(0,0,0, 0,0,2,1,3,1,0,0));
        vecs.push_back(mk(0,1,6, 0,1,2,2,3,1,0,0));
        vecs.push_back(mk(0,1,6, 0,1,2,3,0,0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,2,3,0,0,1,0));
`else
        vecs.push_back(mk(0,1,6, 0,1,2,1,0,0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,2,1,0,0,1,0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            start       = vecs[i].st;
            layer_valid = vecs[i].vld;
            layer_clr   = vecs[i].clr;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i]);
        end
        start       = 1'b0;
        layer_valid = 1'b0;
        layer_clr   = 3'd0;

        // Timeout: one layer, then 16 idle cycles in CHECK
        start_round();
        feed(3'd1);
        chk("to.ok", 32'(layer_ok), 32'd1);
        bad_seen = 1'b0;
        repeat (15) begin
            tick();
            bad_seen = bad_seen | layer_bad;
        end
        chk("to.early_done", 32'(done), 32'd0);
        tick();
        bad_seen = bad_seen | layer_bad;
        chk("to.done",   32'(done),     32'd1);
        chk("to.pass",   32'(pass),     32'd0);
        chk("to.score",  32'(score),    32'd1);
        chk("to.ready",  32'(ready),    32'd0);
        chk("to.misses", 32'(misses),   32'd0);
        chk("to.nobad",  32'(bad_seen), 32'd0);

        // start collides with a layer: start wins, layer dropped
        start_round();
        feed(3'd1);
        chk("col.pre_score", 32'(score), 32'd1);
        start       = 1'b1;
        layer_valid = 1'b1;
        layer_clr   = 3'd2;
        tick();
        start       = 1'b0;
        layer_valid = 1'b0;
        layer_clr   = 3'd0;
        chk("col.score", 32'(score),    32'd0);
        chk("col.ok",    32'(layer_ok), 32'd0);
        chk("col.ready", 32'(ready),    32'd0);
        tick();
        chk("col.ready2", 32'(ready),        32'd1);
        chk("col.exp",    32'(expected_clr), 32'd1);
        chk("col.score2", 32'(score),        32'd0);
        feed(3'd1);
        chk("col.first_ok", 32'(layer_ok), 32'd1);
        chk("col.score3",   32'(score),    32'd1);

        // Reset mid-round at idx=3
        feed(3'd2);
        feed(3'd3);
        chk("mid.score", 32'(score),        32'd3);
        chk("mid.exp",   32'(expected_clr), 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("mid.rst", mk(0,0,0, 0,0,0,0,0,0,0,0));
        feed(3'd1);
        chk("mid.idle_ok",    32'(layer_ok), 32'd0);
        chk("mid.idle_ready", 32'(ready),    32'd0);
        chk("mid.idle_score", 32'(score),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
